// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM encoding,
// byte-enable type and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StCapture,
    StResp
  } lsu_state_e;

  typedef logic [3:0] byte_en_t;

  // 1 when the request must be rejected (illegal width code or misaligned).
  function automatic logic req_bad(input logic       write,
                                   input logic [2:0] funct3,
                                   input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = write;
      F3_H:    bad = addr_lo[0];
      F3_HU:   bad = write | addr_lo[0];
      F3_W:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and ram-side signals of the load/store unit.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_data_out;

  // The unit itself.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_data_in, mem_write_enable, mem_read_enable
  );

  // CPU and ram side together.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_data_in, mem_write_enable, mem_read_enable
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store enables and replicated data, load
// lane extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output byte_en_t    byte_en,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic        is_signed;

  always_comb begin
    byte_shift  = load_word >> {addr_lo, 3'b000};
    half_shift  = load_word >> {addr_lo[1], 4'b0000};
    is_signed   = ~funct3[2];
    byte_en     = 4'b1111;
    store_lanes = store_data;
    load_data   = load_word;
    case (funct3[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << addr_lo;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {{24{is_signed & byte_shift[7]}}, byte_shift[7:0]};
      end
      2'b01: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {{16{is_signed & half_shift[15]}}, half_shift[15:0]};
      end
      default: begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
        load_data   = load_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a fixed-latency ram: request
// latching, legality check, access sequencing and response registers.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          WORD_ADDRESSED = 1'b1
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        req_err;
  byte_en_t    byte_en;
  logic [31:0] store_lanes;
  logic [31:0] load_data;

  assign accept  = bus.req_valid && (state_q == StIdle);
  assign req_err = req_bad(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

  lsu_lane_align u_align (
    .funct3      (funct3_q),
    .addr_lo     (addr_q[1:0]),
    .store_data  (wdata_q),
    .load_word   (bus.mem_data_out),
    .byte_en     (byte_en),
    .store_lanes (store_lanes),
    .load_data   (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StResp;
          end else begin
            state_d = StAccess;
            cnt_d   = 3'(READ_LATENCY - 1);
          end
        end
      end
      StAccess: begin
        // Stores take one cycle; loads hold the read for READ_LATENCY cycles.
        if (write_q) begin
          state_d = StResp;
        end else if (cnt_q == 3'd0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StCapture: state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= bus.req_write;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
      // Response fields change only on the edge entering StResp.
      if (accept && req_err) begin
        rdata_q <= '0;
        error_q <= 1'b1;
      end else if (state_q == StAccess && write_q) begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end else if (state_q == StCapture) begin
        rdata_q <= load_data;
        error_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready        = (state_q == StIdle);
  assign bus.resp_valid       = (state_q == StResp);
  assign bus.resp_rdata       = rdata_q;
  assign bus.resp_error       = error_q;
  assign bus.mem_address      = WORD_ADDRESSED ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
  assign bus.mem_data_in      = store_lanes;
  assign bus.mem_write_enable = (state_q == StAccess && write_q) ? byte_en : 4'b0000;
  assign bus.mem_read_enable  = (state_q == StAccess) && !write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: byte-array reference model predicts ram writes, ram reads
// and responses; a negedge monitor checks them as the unit produces them.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned RL = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  lsu_if bus ();

  load_store_unit #(
    .READ_LATENCY   (RL),
    .WORD_ADDRESSED (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ram, one-cycle read latency, word indexed.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.mem_write_enable[i]) ram[bus.mem_address[7:0]][8*i +: 8] <= bus.mem_data_in[8*i +: 8];
    if (bus.mem_read_enable) bus.mem_data_out <= ram[bus.mem_address[7:0]];
  end

  logic [7:0] refmem [1024];

  typedef struct {logic [31:0] rdata; logic err; int acc; int lat;} resp_t;
  typedef struct {logic [3:0] be; logic [31:0] data; logic [31:0] addr;} wr_t;
  resp_t       sq[$];
  wr_t         wq[$];
  logic [31:0] rq[$];

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  int last_resp_cyc = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected event, required none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_write_enable != 4'b0000) begin
        wr_t w;
        if (wq.size() == 0) fail_evt("unexpected_write");
        else begin
          w = wq.pop_front();
          chk("store_be", 32'(bus.mem_write_enable), 32'(w.be));
          chk("store_data", bus.mem_data_in, w.data);
          chk("store_addr", bus.mem_address, w.addr);
          chk("store_no_read", 32'(bus.mem_read_enable), 32'd0);
        end
      end
      if (bus.mem_read_enable) begin
        logic [31:0] ra;
        if (rq.size() == 0) fail_evt("unexpected_read");
        else begin
          ra = rq.pop_front();
          chk("read_addr", bus.mem_address, ra);
        end
      end
      if (bus.resp_valid) begin
        resp_t r;
        if (sq.size() == 0) fail_evt("unexpected_resp");
        else begin
          r = sq.pop_front();
          chk("resp_rdata", bus.resp_rdata, r.rdata);
          chk("resp_error", 32'(bus.resp_error), 32'(r.err));
          chk("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
        last_resp_cyc = cyc;
      end
    end
  end

  // Drives one request, predicts its effects from the byte model, and returns
  // just after the accepting edge.
  task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit hold, input bit gap_chk,
                       input bit want_resp);
    int     n, guard, acc;
    bit     legal, err, sgn;
    longint val;
    resp_t  r;
    wr_t    wr;
    @(negedge clk);
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_valid  = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got req_ready 0 for 50 cycles, required 1");
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (gap_chk) chk("b2b_accept_cycle", 32'(acc), 32'(last_resp_cyc + 2));
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal;
    if (legal) err = (a % n) != 0;
    sgn   = (f3 == F3_B) || (f3 == F3_H);
    r.err = err;
    r.rdata = 32'd0;
    r.acc = acc;
    r.lat = err ? 0 : (w ? 1 : int'(RL) + 1);
    if (!err) begin
      if (w) begin
        wr.be = 4'b0000;
        wr.data = 32'd0;
        for (int i = 0; i < n; i++) begin
          wr.be[(a % 4) + i] = 1'b1;
          refmem[a + i] = 8'(d >> (8 * i));
        end
        for (int i = 0; i < 4; i++) wr.data[8*i +: 8] = 8'(d >> (8 * (i % n)));
        wr.addr = a >> 2;
        wq.push_back(wr);
      end else begin
        val = 0;
        for (int i = 0; i < n; i++) val = val | (longint'(refmem[a + i]) << (8 * i));
        if (sgn && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
        r.rdata = val[31:0];
        for (int i = 0; i < int'(RL); i++) rq.push_back(a >> 2);
      end
    end
    if (want_resp) sq.push_back(r);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    for (int i = 0; i < 1024; i++) refmem[i] = 8'd0;
    // A store presented during reset must be ignored.
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    mon_en = 1'b1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
    chk("rst_we", 32'(bus.mem_write_enable), 32'd0);
    chk("rst_re", 32'(bus.mem_read_enable), 32'd0);
    chk("rst_addr", bus.mem_address, 32'd0);
    chk("rst_data_in", bus.mem_data_in, 32'd0);

    issue(1, F3_W, 32'h28, 32'h0000_002A, 0, 0, 1);
    issue(0, F3_W, 32'h28, 32'h0, 0, 0, 1);
    issue(0, F3_W, 32'h0, 32'h0, 0, 0, 1);
    issue(1, F3_W, 32'h10, 32'h8000_FF7F, 0, 0, 1);
    issue(0, F3_B, 32'h10, 32'h0, 0, 0, 1);
    issue(0, F3_B, 32'h11, 32'h0, 0, 0, 1);
    issue(0, F3_BU, 32'h11, 32'h0, 0, 0, 1);
    issue(0, F3_H, 32'h12, 32'h0, 0, 0, 1);
    issue(0, F3_HU, 32'h12, 32'h0, 0, 0, 1);
    issue(1, F3_B, 32'h23, 32'h0000_00AB, 0, 0, 1);
    issue(1, F3_H, 32'h22, 32'h0000_1234, 0, 0, 1);
    issue(0, F3_W, 32'h20, 32'h0, 0, 0, 1);
    issue(0, F3_W, 32'h21, 32'h0, 0, 0, 1);
    issue(0, F3_H, 32'h03, 32'h0, 0, 0, 1);
    issue(0, 3'b011, 32'h40, 32'h0, 0, 0, 1);
    issue(1, F3_BU, 32'h40, 32'h55, 0, 0, 1);

    // Two loads with req_valid held high throughout.
    issue(0, F3_W, 32'h10, 32'h0, 1, 0, 1);
    issue(0, F3_H, 32'h10, 32'h0, 0, 1, 1);

    // Reset in the middle of a load access: read happens, no response.
    issue(0, F3_W, 32'h10, 32'h0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_we", 32'(bus.mem_write_enable), 32'd0);
    chk("post_rst_re", 32'(bus.mem_read_enable), 32'd0);
    chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    issue(1, F3_W, 32'h30, 32'hCAFE_F00D, 0, 0, 1);
    issue(0, F3_W, 32'h30, 32'h0, 0, 0, 1);

    for (int k = 0; k < 300; k++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      bit          w;
      int          n;
      w  = $urandom_range(0, 1) == 1;
      f3 = ($urandom_range(0, 9) < 8) ? (w ? 3'($urandom_range(0, 2))
                                            : ((($urandom_range(0, 4)) inside {3, 4}) ?
                                               3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2))))
                                      : 3'($urandom_range(0, 7));
      n  = (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 1;
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) < 8) a = a & ~32'(n - 1);
      issue(w, f3, a, 32'($urandom), 0, 0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (sq.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 32'(sq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
